// File: rtl/dec_pkg.sv
// Shared definitions for the N-to-2^N scanning decoder.
//   MODE_*  : encodings of the 2-bit mode input (2'b11 is reserved and decodes as direct)
//   clog2() : counter width helper, never returns less than 1 so that
//             degenerate parameter values still give a legal vector width
package dec_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned k = 1; k < 32; k++) begin
      if ((32'd1 << k) < value) width = k + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2^N one-hot decoder, no enable.
//   sel    [N-1:0]    : index to decode
//   onehot [2**N-1:0] : bit k is 1 exactly when sel == k
module dec_onehot #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned k = 0; k < 2**N; k++) begin
      onehot[k] = (sel == N'(k));
    end
  end

endmodule

// File: rtl/dec_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with direct, auto-scan and one-shot pulse modes.
//   clk, rst : clock and synchronous active-high reset
//   en       : global enable; low forces o inactive and freezes all counters
//   mode     : 00 direct, 01 scan, 10 pulse, 11 treated as direct
//   i        : select index for direct mode and pulse capture
//   load     : pulse-mode trigger
//   o        : registered one-hot output (inverted when ACTIVE_LOW)
//   idx      : index currently active, 0 when nothing is active
//   wrap     : one-cycle strobe when the scan index rolls over to 0
//   busy     : pulse in progress
module dec_scan_nto2n
  import dec_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned PULSE_LEN  = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    i,
  input  logic            load,
  output logic [2**N-1:0] o,
  output logic [N-1:0]    idx,
  output logic            wrap,
  output logic            busy
);

  localparam int unsigned W  = 2**N;
  localparam int unsigned PW = clog2(SCAN_DIV);
  localparam int unsigned CW = clog2(PULSE_LEN + 1);

  logic [1:0]    mode_q;
  logic [N-1:0]  scan_idx_q, scan_idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  cap_q, cap_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [W-1:0]  o_q, o_d;

  logic          mode_chg;
  logic          active_d;
  logic [N-1:0]  sel_d;
  logic [W-1:0]  onehot;

  dec_onehot #(
    .N (N)
  ) u_onehot (
    .sel    (sel_d),
    .onehot (onehot)
  );

  assign mode_chg = (mode != mode_q);

  always_comb begin
    scan_idx_d = scan_idx_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    busy_d     = busy_q;
    wrap_d     = 1'b0;
    active_d   = 1'b0;
    sel_d      = i;

    // A mode change restarts scanning and aborts a pulse, even while disabled.
    if (mode_chg) begin
      scan_idx_d = '0;
      presc_d    = '0;
      cnt_d      = '0;
      busy_d     = 1'b0;
    end

    if (en) begin
      if (mode == MODE_SCAN) begin
        // The entry edge shows index 0 and counts as its first prescaler cycle.
        if (!mode_chg) begin
          if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d    = '0;
            scan_idx_d = scan_idx_q + N'(1);
            wrap_d     = &scan_idx_q;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        sel_d    = scan_idx_d;
        active_d = 1'b1;
      end else if (mode == MODE_PULSE) begin
        // Load on the entry edge is dropped: the mode change wins.
        if (!mode_chg) begin
          if (busy_q) begin
            // cnt_q counts cycles already shown; stop once PULSE_LEN have been shown.
            if (cnt_q == CW'(PULSE_LEN)) begin
              busy_d = 1'b0;
              cnt_d  = '0;
            end else begin
              cnt_d    = cnt_q + CW'(1);
              sel_d    = cap_q;
              active_d = 1'b1;
            end
          end else if (load) begin
            busy_d   = 1'b1;
            cnt_d    = CW'(1);
            cap_d    = i;
            sel_d    = i;
            active_d = 1'b1;
          end
        end
      end else begin
        sel_d    = i;
        active_d = 1'b1;
      end
    end

    idx_d = active_d ? sel_d : '0;
    o_d   = (active_d ? onehot : '0) ^ {W{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_DIRECT;
      scan_idx_q <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      idx_q      <= '0;
      o_q        <= {W{ACTIVE_LOW}};
    end else begin
      mode_q     <= mode;
      scan_idx_q <= scan_idx_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      idx_q      <= idx_d;
      o_q        <= o_d;
    end
  end

  assign o    = o_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule
